// File: rtl/mult_seq.sv
// Iterative radix-2 shift-add multiplier, signed or unsigned N x N -> 2N product.
// Latency: done pulses N+1 cycles after the accepted start; issue interval N+2 cycles.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped.
module mult_seq #(
  parameter int N = 9
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           is_signed,
  input  logic [N-1:0]   x1,
  input  logic [N-1:0]   x2,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] y
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*N:0]     acc_q, acc_d;     // extra top bit catches the add carry before the shift
  logic [N-1:0]     mcand_q, mcand_d; // multiplicand magnitude
  logic [N-1:0]     mplr_q, mplr_d;   // multiplier magnitude, consumed LSB first
  logic             neg_q, neg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [2*N-1:0]   y_q, y_d;

  logic [N-1:0]     x1_mag, x2_mag;
  logic [N:0]       sum;
  logic [2*N:0]     acc_sum;

  // Operand magnitudes; -2^(N-1) negates to 2^(N-1), which still fits in N unsigned bits.
  always_comb begin
    x1_mag = (is_signed && x1[N-1]) ? (~x1 + 1'b1) : x1;
    x2_mag = (is_signed && x2[N-1]) ? (~x2 + 1'b1) : x2;
  end

  // One shift-add step: conditionally add the multiplicand into the upper half, then shift right.
  always_comb begin
    sum     = acc_q[2*N:N] + {1'b0, (mplr_q[0] ? mcand_q : {N{1'b0}})};
    acc_sum = {sum, acc_q[N-1:0]} >> 1;
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    neg_d   = neg_q;
    done_d  = 1'b0;
    y_d     = y_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = x1_mag;
          mplr_d  = x2_mag;
          neg_d   = is_signed & (x1[N-1] ^ x2[N-1]);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d  = acc_sum;
        mplr_d = mplr_q >> 1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          state_d = FIN;
        end
      end
      FIN: begin
        y_d     = neg_q ? (~acc_q[2*N-1:0] + 1'b1) : acc_q[2*N-1:0];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // busy stays up through the done cycle so it covers CALC and FIN as seen by the consumer.
    busy_d = (state_d != IDLE) || (state_q == FIN);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      neg_q   <= neg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      y_q     <= y_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign y    = y_q;

endmodule

// File: tb/tb_mult_seq.sv
// Bench for mult_seq: directed corner cases plus random operands against an arithmetic model.
module tb_mult_seq;

  localparam int N = 9;
  localparam int NRAND = 3000;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic           is_signed;
  logic [N-1:0]   x1;
  logic [N-1:0]   x2;
  logic           busy;
  logic           done;
  logic [2*N-1:0] y;

  int n_chk;
  int n_bad;
  logic [2*N-1:0] prev_y;

  mult_seq #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .x1        (x1),
    .x2        (x2),
    .busy      (busy),
    .done      (done),
    .y         (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: interpret operands as integers and multiply, keeping the low 2N bits.
  function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b,
                                             input logic s);
    longint va, vb;
    logic [63:0] p;
    va = longint'(a);
    vb = longint'(b);
    if (s && a[N-1]) va = va - (longint'(1) << N);
    if (s && b[N-1]) vb = vb - (longint'(1) << N);
    p = 64'(va * vb);
    return p[2*N-1:0];
  endfunction

  // One transaction: pulse start, scramble inputs while busy, check latency, busy, y and pulse width.
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                       input string tag);
    logic [2*N-1:0] exp;
    int k;
    bit seen;
    bit busy_ok;
    exp = ref_mul(a, b, s);
    @(negedge clk);
    x1 = a; x2 = b; is_signed = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    x1 = N'($urandom); x2 = N'($urandom); is_signed = 1'($urandom);
    busy_ok = (busy === 1'b1);
    k = 0;
    seen = 0;
    while (!seen && k < 4 * N) begin
      if (k == N) check({tag, "_yhold"}, 64'(y), 64'(prev_y));
      @(posedge clk); #1;
      k++;
      if (done === 1'b1) seen = 1;
      if (busy !== 1'b1) busy_ok = 0;
    end
    check({tag, "_lat"}, 64'(k), 64'(N + 1));
    check({tag, "_y"}, 64'(y), 64'(exp));
    check({tag, "_busy"}, 64'(busy_ok), 64'd1);
    @(posedge clk); #1;
    check({tag, "_pulse"}, 64'({done, busy}), 64'd0);
    prev_y = exp;
  endtask

  initial begin
    int d_cnt;
    int d_first;
    int d_second;
    bit bad_done;
    n_chk = 0;
    n_bad = 0;
    prev_y = '0;
    rst_n = 1'b0;
    start = 1'b0;
    is_signed = 1'b0;
    x1 = '0;
    x2 = '0;
    #22;
    check("rst_state", 64'({busy, done, y}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed corners.
    do_op(9'd511, 9'd511, 1'b0, "u_max");
    do_op(9'h100, 9'h100, 1'b1, "s_minmin");
    do_op(9'h100, 9'h0FF, 1'b1, "s_minpos");
    do_op(9'h1FF, 9'h0FF, 1'b1, "s_neg1");
    do_op(9'h1FF, 9'h0FF, 1'b0, "u_neg1");
    do_op(9'h000, 9'h1FF, 1'b1, "s_zero");

    // Second start during CALC must be dropped.
    @(negedge clk);
    x1 = 9'd3; x2 = 9'd5; is_signed = 1'b0; start = 1'b1;
    d_cnt = 0;
    for (int i = 0; i < 2 * N + 10; i++) begin
      @(posedge clk); #1;
      if (i == 0) start = 1'b0;
      if (i == 3) begin x1 = 9'd7; x2 = 9'd7; start = 1'b1; end
      if (i == 4) start = 1'b0;
      if (done === 1'b1) d_cnt++;
    end
    check("ign_done_cnt", 64'(d_cnt), 64'd1);
    check("ign_y", 64'(y), 64'd15);

    // Start held high: back-to-back issue every N+2 cycles.
    @(negedge clk);
    x1 = 9'd3; x2 = 9'd5; is_signed = 1'b0; start = 1'b1;
    d_cnt = 0; d_first = -1; d_second = -1;
    for (int i = 0; i <= 2 * N + 6; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        d_cnt++;
        if (d_first < 0) d_first = i; else if (d_second < 0) d_second = i;
      end
    end
    start = 1'b0;
    check("b2b_cnt", 64'(d_cnt), 64'd2);
    check("b2b_first", 64'(d_first), 64'(N + 1));
    check("b2b_gap", 64'(d_second - d_first), 64'(N + 2));
    check("b2b_y", 64'(y), 64'd15);
    repeat (2 * N) @(posedge clk);
    prev_y = 18'd15;

    // Reset in the middle of CALC aborts the operation without a done.
    do_op(9'd511, 9'd511, 1'b0, "pre_rst");
    @(negedge clk);
    x1 = 9'd100; x2 = 9'd200; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst", 64'({busy, done, y}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad_done = 0;
    for (int i = 0; i < 2 * N + 4; i++) begin
      @(posedge clk); #1;
      if (done !== 1'b0) bad_done = 1;
    end
    check("no_done_after_rst", 64'(bad_done), 64'd0);
    prev_y = '0;
    do_op(9'h000, 9'h1FF, 1'b1, "rst_zero");

    // Random regression in both modes.
    for (int t = 0; t < NRAND; t++) begin
      do_op(N'($urandom), N'($urandom), 1'($urandom), "rand");
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout total=%0d bad=%0d", n_chk, n_bad);
    $fatal(1);
  end

endmodule
